// File: rtl/multicycle_controller.sv
// multicycle_controller
// Multi-cycle control FSM for an RV32I datapath. Each instruction moves
// through FETCH -> DECODE -> EXEC -> (MEM) -> WB. The FSM drives the datapath
// write strobes, mux selects and alu_op. It runs a req/ready handshake with a
// shared instruction/data memory, traps on a memory timeout or an illegal
// encoding, and counts retired instructions.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   instruction[31:0]    instruction register contents (valid from DECODE)
//   mem_ready            memory completes the current request this cycle
//   mem_req, mem_we      memory request / store qualifier
//   addr_sel             0 = PC addresses memory, 1 = ALU result register
//   ir_write, alu_out_write, mdr_write, reg_write, pc_write   datapath strobes
//   wb_sel               0 = ALU result, 1 = memory data to register file
//   alu_op[2:0], use_imm ALU control, registered at the end of DECODE
//   state[2:0]           FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//   illegal_insn, bus_fault   sticky trap causes
//   retired_count        completed instruction count (wraps)
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instruction,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 ir_write,
    output logic                 alu_out_write,
    output logic                 mdr_write,
    output logic                 reg_write,
    output logic                 wb_sel,
    output logic                 pc_write,
    output logic [2:0]           alu_op,
    output logic                 use_imm,
    output logic [2:0]           state,
    output logic                 illegal_insn,
    output logic                 bus_fault,
    output logic [CNT_WIDTH-1:0] retired_count
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd5
    } state_t;

    typedef enum logic [1:0] {C_ALU = 2'd0, C_LOAD = 2'd1, C_STORE = 2'd2} class_t;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                           OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_SLT = 3'd7;

    // Wait counter only needs to reach MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t                state_reg, state_next;
    logic [WAIT_W-1:0]     wait_cnt_reg;
    logic [2:0]            alu_op_reg;
    logic                  use_imm_reg;
    class_t                class_reg;
    logic                  illegal_reg, bus_fault_reg;
    logic [CNT_WIDTH-1:0]  retired_reg;

    // ---------------- instruction decode ----------------
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       f7_zero, f7_sub;
    logic       dec_ok, dec_imm;
    logic [2:0] dec_op, f3_op;
    class_t     dec_class;
    logic       unused_fields;

    assign opcode        = instruction[6:0];
    assign funct3        = instruction[14:12];
    assign funct7        = instruction[31:25];
    assign f7_zero       = (funct7 == 7'b0000000);
    assign f7_sub        = (funct7 == 7'b0100000);
    assign unused_fields = ^{instruction[24:15], instruction[11:7]};

    always_comb begin
        f3_op = OP_ADD;
        case (funct3)
            3'b111:  f3_op = OP_AND;
            3'b110:  f3_op = OP_OR;
            3'b100:  f3_op = OP_XOR;
            3'b010:  f3_op = OP_SLT;
            3'b001:  f3_op = OP_SLL;
            3'b101:  f3_op = OP_SRL;
            default: f3_op = OP_ADD;
        endcase
    end

    always_comb begin
        dec_ok    = 1'b0;
        dec_op    = f3_op;
        dec_imm   = 1'b0;
        dec_class = C_ALU;
        case (opcode)
            7'b0110011: begin
                // R-type: funct7 must be zero except for SUB; SLTU (011) is not supported.
                if (funct3 == 3'b000) begin
                    dec_ok = f7_zero | f7_sub;
                    dec_op = f7_sub ? OP_SUB : OP_ADD;
                end else begin
                    dec_ok = f7_zero && (funct3 != 3'b011);
                end
            end
            7'b0010011: begin
                // I-ALU: the upper immediate bits only matter for shifts.
                dec_imm = 1'b1;
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    dec_ok = f7_zero;
                else
                    dec_ok = (funct3 != 3'b011);
            end
            7'b0000011: begin
                dec_ok    = (funct3 == 3'b010);
                dec_op    = OP_ADD;
                dec_imm   = 1'b1;
                dec_class = C_LOAD;
            end
            7'b0100011: begin
                dec_ok    = (funct3 == 3'b010);
                dec_op    = OP_ADD;
                dec_imm   = 1'b1;
                dec_class = C_STORE;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // ---------------- next state ----------------
    logic timeout_hit;
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_reg == WAIT_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                // A ready on the last allowed cycle still completes normally.
                if (mem_ready)        state_next = S_DECODE;
                else if (timeout_hit) state_next = S_TRAP;
            end
            S_DECODE: state_next = dec_ok ? S_EXEC : S_TRAP;
            S_EXEC:   state_next = (class_reg == C_ALU) ? S_WB : S_MEM;
            S_MEM: begin
                if (mem_ready)        state_next = (class_reg == C_STORE) ? S_FETCH : S_WB;
                else if (timeout_hit) state_next = S_TRAP;
            end
            S_WB:     state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH;
        endcase
    end

    logic retire;
    assign retire = (state_reg == S_WB) ||
                    (state_reg == S_MEM && mem_ready && class_reg == C_STORE);

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_FETCH;
            wait_cnt_reg  <= '0;
            alu_op_reg    <= OP_ADD;
            use_imm_reg   <= 1'b0;
            class_reg     <= C_ALU;
            illegal_reg   <= 1'b0;
            bus_fault_reg <= 1'b0;
            retired_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg)
                wait_cnt_reg <= '0;
            else if ((state_reg == S_FETCH || state_reg == S_MEM) && !mem_ready)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;

            if (state_reg == S_DECODE) begin
                alu_op_reg  <= dec_op;
                use_imm_reg <= dec_imm;
                class_reg   <= dec_class;
                if (!dec_ok)
                    illegal_reg <= 1'b1;
            end
            if ((state_reg == S_FETCH || state_reg == S_MEM) && state_next == S_TRAP)
                bus_fault_reg <= 1'b1;
            if (retire)
                retired_reg <= retired_reg + 1'b1;
        end
    end

    // ---------------- outputs ----------------
    // Strobes come from the registered state; reset forces them quiet so an
    // aborted instruction cannot write anything in the reset cycle.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 1'b0;
        ir_write      = 1'b0;
        alu_out_write = 1'b0;
        mdr_write     = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = 1'b0;
        pc_write      = 1'b0;
        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                S_EXEC: alu_out_write = 1'b1;
                S_MEM: begin
                    mem_req   = 1'b1;
                    addr_sel  = 1'b1;
                    mem_we    = (class_reg == C_STORE);
                    mdr_write = mem_ready && (class_reg == C_LOAD);
                    pc_write  = mem_ready && (class_reg == C_STORE);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = (class_reg == C_LOAD);
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign alu_op        = reset ? OP_ADD : alu_op_reg;
    assign use_imm       = reset ? 1'b0   : use_imm_reg;
    assign illegal_insn  = reset ? 1'b0   : illegal_reg;
    assign bus_fault     = reset ? 1'b0   : bus_fault_reg;
    assign retired_count = reset ? '0     : retired_reg;
    assign state         = state_reg;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (MEM_TIMEOUT=4). Expected states
// and strobe patterns are hand-derived from the FSM description.
module tb_multicycle_controller;
    logic        clk, reset, mem_ready;
    logic [31:0] instruction;
    logic        mem_req, mem_we, addr_sel, ir_write, alu_out_write, mdr_write;
    logic        reg_write, wb_sel, pc_write, use_imm, illegal_insn, bus_fault;
    logic [2:0]  alu_op, state;
    logic [31:0] retired_count;

    int total = 0;
    int bad   = 0;

    multicycle_controller #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .alu_out_write(alu_out_write), .mdr_write(mdr_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .pc_write(pc_write), .alu_op(alu_op), .use_imm(use_imm),
        .state(state), .illegal_insn(illegal_insn), .bus_fault(bus_fault),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req, mem_we, addr_sel, ir_write, alu_out_write, mdr_write, reg_write, wb_sel, pc_write}
    logic [8:0] sb;
    assign sb = {mem_req, mem_we, addr_sel, ir_write, alu_out_write, mdr_write,
                 reg_write, wb_sel, pc_write};

    localparam logic [8:0] SB_NONE = 9'h000, SB_F_WAIT = 9'h100, SB_F_RDY = 9'h120,
                           SB_EXEC = 9'h010, SB_WB_ALU = 9'h005, SB_WB_LD = 9'h007,
                           SB_M_LD_WAIT = 9'h140, SB_M_LD_RDY = 9'h148, SB_M_ST_RDY = 9'h1C1;

    localparam logic [31:0] I_ADD  = 32'h005303B3, I_SUB  = 32'h40848533,
                            I_ADDI = 32'h00160693, I_SLL  = 32'h005313B3,
                            I_LW   = 32'h0000A283, I_SW   = 32'h0050A023;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive ready, check state and strobes mid-cycle, advance.
    task automatic cyc(input string tag, input logic rdy, input logic [2:0] st, input logic [8:0] s);
        mem_ready = rdy;
        @(negedge clk);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".strobes"}, 32'(sb), 32'(s));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic alu_insn(input string tag, input logic [31:0] insn, input logic [2:0] op,
                            input logic imm, input logic [31:0] exp_ret);
        instruction = insn;
        cyc({tag, ".F"}, 1'b1, 3'd0, SB_F_RDY);
        cyc({tag, ".D"}, 1'b0, 3'd1, SB_NONE);
        cyc({tag, ".E"}, 1'b0, 3'd2, SB_EXEC);
        check({tag, ".alu_op"}, 32'(alu_op), 32'(op));
        check({tag, ".use_imm"}, 32'(use_imm), 32'(imm));
        cyc({tag, ".W"}, 1'b0, 3'd4, SB_WB_ALU);
        check({tag, ".retired"}, retired_count, exp_ret);
        $display("insn %s retired=%0d", tag, retired_count);
    endtask

    logic [31:0] bad_insn [4];

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        instruction = 32'h0;
        bad_insn = '{32'h00000000, 32'h0062B3B3, 32'h4062D3B3, 32'h4012D393};

        // Reset values
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst.strobes", 32'(sb), 32'(SB_NONE));
        check("rst.alu_op", 32'(alu_op), 32'd0);
        check("rst.use_imm", 32'(use_imm), 32'd0);
        check("rst.flags", 32'({illegal_insn, bus_fault}), 32'd0);
        check("rst.retired", retired_count, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ALU instructions, zero-wait memory
        alu_insn("add", I_ADD, 3'd0, 1'b0, 32'd1);
        alu_insn("sub", I_SUB, 3'd1, 1'b0, 32'd2);
        alu_insn("addi", I_ADDI, 3'd0, 1'b1, 32'd3);
        alu_insn("sll", I_SLL, 3'd5, 1'b0, 32'd4);

        // Load with three wait cycles in MEM (8 cycles); ready outside FETCH/MEM ignored
        instruction = I_LW;
        cyc("lw.F", 1'b1, 3'd0, SB_F_RDY);
        cyc("lw.D", 1'b1, 3'd1, SB_NONE);
        cyc("lw.E", 1'b1, 3'd2, SB_EXEC);
        check("lw.use_imm", 32'(use_imm), 32'd1);
        for (int i = 0; i < 3; i++) cyc("lw.Mwait", 1'b0, 3'd3, SB_M_LD_WAIT);
        cyc("lw.Mrdy", 1'b1, 3'd3, SB_M_LD_RDY);
        cyc("lw.W", 1'b1, 3'd4, SB_WB_LD);
        check("lw.retired", retired_count, 32'd5);
        $display("insn lw retired=%0d", retired_count);

        // Store, zero-wait
        instruction = I_SW;
        cyc("sw.F", 1'b1, 3'd0, SB_F_RDY);
        cyc("sw.D", 1'b0, 3'd1, SB_NONE);
        cyc("sw.E", 1'b0, 3'd2, SB_EXEC);
        cyc("sw.M", 1'b1, 3'd3, SB_M_ST_RDY);
        check("sw.retired", retired_count, 32'd6);
        $display("insn sw retired=%0d", retired_count);

        // Fetch ready on the 4th cycle beats the timeout
        instruction = I_ADD;
        for (int i = 0; i < 3; i++) cyc("fw.Fwait", 1'b0, 3'd0, SB_F_WAIT);
        cyc("fw.F", 1'b1, 3'd0, SB_F_RDY);
        cyc("fw.D", 1'b0, 3'd1, SB_NONE);
        cyc("fw.E", 1'b0, 3'd2, SB_EXEC);
        cyc("fw.W", 1'b0, 3'd4, SB_WB_ALU);
        check("fw.retired", retired_count, 32'd7);
        check("fw.bus_fault", 32'(bus_fault), 32'd0);
        $display("insn fetch-wait retired=%0d", retired_count);

        // Fetch timeout: TRAP on the 5th cycle, then ready pulses do nothing
        for (int i = 0; i < 4; i++) cyc("to.Fwait", 1'b0, 3'd0, SB_F_WAIT);
        cyc("to.trap", 1'b1, 3'd5, SB_NONE);
        check("to.bus_fault", 32'(bus_fault), 32'd1);
        check("to.illegal", 32'(illegal_insn), 32'd0);
        cyc("to.trap2", 1'b1, 3'd5, SB_NONE);
        check("to.retired", retired_count, 32'd7);
        $display("insn timeout bus_fault=%0d", bus_fault);

        // Reset in MEM of a store aborts it
        do_reset();
        check("rs.bus_fault", 32'(bus_fault), 32'd0);
        instruction = I_SW;
        cyc("rs.F", 1'b1, 3'd0, SB_F_RDY);
        cyc("rs.D", 1'b0, 3'd1, SB_NONE);
        cyc("rs.E", 1'b0, 3'd2, SB_EXEC);
        mem_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("rs.Mstrobes", 32'(sb), 32'(SB_NONE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("rs.after", 1'b0, 3'd0, SB_F_WAIT);
        check("rs.retired", retired_count, 32'd0);
        $display("insn reset-abort retired=%0d", retired_count);

        // Illegal encodings: 0, SLTU, SRA, SRAI-style funct7
        for (int k = 0; k < 4; k++) begin
            do_reset();
            instruction = bad_insn[k];
            cyc("ill.F", 1'b1, 3'd0, SB_F_RDY);
            cyc("ill.D", 1'b0, 3'd1, SB_NONE);
            cyc("ill.trap", 1'b1, 3'd5, SB_NONE);
            check("ill.flag", 32'(illegal_insn), 32'd1);
            check("ill.bus_fault", 32'(bus_fault), 32'd0);
            cyc("ill.trap2", 1'b1, 3'd5, SB_NONE);
            check("ill.retired", retired_count, 32'd0);
            $display("insn illegal %h illegal_insn=%0d", bad_insn[k], illegal_insn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the RV32I datapath (pc, instruction_memory, register_file, alu, sign_extend).
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives all datapath write strobes, mux selects and alu_op.
- Talks to a shared instruction/data memory with a req/ready handshake, enforces a memory timeout, traps on illegal encodings, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16, max request cycles without mem_ready before a bus fault; 0 disables the timeout.
- CNT_WIDTH, 32, width of retired_count.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- instruction  input  32  instruction register contents; valid from DECODE onward
- mem_ready  input  1  memory completes the current request this cycle
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  store request; valid only with mem_req
- addr_sel  output  1  0 = PC drives the memory address, 1 = ALU result register
- ir_write  output  1  load the instruction register
- alu_out_write  output  1  latch the ALU result
- mdr_write  output  1  latch memory read data
- reg_write  output  1  register_file write_enable
- wb_sel  output  1  0 = ALU result, 1 = memory data to data_in
- pc_write  output  1  load pc with pc+4
- alu_op  output  3  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7
- use_imm  output  1  ALU b input = sign-extended immediate
- state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
- illegal_insn  output  1  sticky; set on entry to TRAP for a decode fault
- bus_fault  output  1  sticky; set on entry to TRAP for a timeout
- retired_count  output  CNT_WIDTH  number of instructions completed

Behaviour:
- While reset is high, all strobes are 0, mem_req=0, alu_op=ADD, use_imm=0, flags=0 and retired_count=0. The first cycle after reset is in FETCH with the wait counter at 0.
- Reset mid-instruction aborts it: no strobe fires in the reset cycle and nothing is retired.
- Strobes are decoded from the registered state, plus mem_ready in FETCH and MEM. alu_op and use_imm are registered at the end of DECODE and stay stable through EXEC, MEM and WB.
- FETCH: mem_req=1, mem_we=0, addr_sel=0.
  - mem_ready=1: ir_write=1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle. The decode rules are:
  - opcode 0110011 (R-type), use_imm=0:
    - funct3 000 gives ADD if funct7=0000000, SUB if funct7=0100000.
    - 111 gives AND, 110 OR, 100 XOR, 010 SLT.
    - 001 gives SLL and 101 gives SRL, both only with funct7=0000000.
  - opcode 0010011 (I-ALU), use_imm=1:
    - 000 gives ADD.
    - 111/110/100/010 map as for R-type.
    - 001/101 require funct7=0000000.
  - opcode 0000011 (load) and 0100011 (store): funct3 must be 010, alu_op=ADD, use_imm=1.
  - Anything else, including 32'h0, SLTU, SRA and SUB-coded funct7 on other funct3 values, goes to TRAP with illegal_insn=1.
- EXEC: alu_out_write=1 for one cycle. R-type and I-ALU go to WB; load and store go to MEM.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for a store and 0 for a load.
  - On mem_ready for a store: pc_write=1, retired_count increments, go to FETCH.
  - On mem_ready for a load: mdr_write=1, go to WB.
- WB: reg_write=1, wb_sel=1 for a load and 0 otherwise, pc_write=1, retired_count increments, go to FETCH.
- Cycle counts with zero-wait memory: R-type, I-ALU and store take 4 cycles; load takes 5. Each memory wait cycle adds 1.
- Timeout:
  - wait_cnt counts consecutive mem_ready=0 cycles in FETCH or MEM and is cleared on every state change.
  - If MEM_TIMEOUT≠0, mem_ready=0 and wait_cnt==MEM_TIMEOUT-1, the next state is TRAP and bus_fault is set.
  - mem_ready=1 on that same cycle wins and completes normally.
- TRAP: all strobes 0 and mem_req=0. The controller stays in TRAP until reset; the flags and retired_count hold.
- mem_ready outside FETCH and MEM is ignored.
- retired_count wraps modulo 2^CNT_WIDTH.

Test Plan:
- Sequence "add x7,x6,x5" then "sub x10,x9,x8" then "addi x13,x12,1" with zero-wait memory and registers initialised to 3000+i:
  - state follows 0,1,2,4 per instruction.
  - Each instruction gets reg_write and pc_write on its 4th cycle.
  - alu_op is ADD, then SUB, then ADD; use_imm is 0, 0, 1.
  - Results: x7=6011, x10=1, x13=3013, retired_count=3.
- "lw" (funct3 010) with mem_ready held low for 3 cycles in MEM:
  - The instruction completes in 8 cycles.
  - mdr_write pulses with ready, then WB has wb_sel=1 and reg_write=1.
- "sw" with zero-wait memory:
  - MEM has mem_we=1 and addr_sel=1.
  - No reg_write is issued; pc_write fires on cycle 4.
- Instruction 32'h00000000 → TRAP after DECODE with illegal_insn=1. mem_ready pulses afterwards cause no strobes; retired_count unchanged.
- MEM_TIMEOUT=4 with mem_ready=0 in FETCH:
  - state=5 and bus_fault=1 on the 5th cycle.
  - Repeat with ready on the 4th cycle → normal DECODE.
- Assert reset in MEM of a store → no mem_we or pc_write in that cycle, state=0 next cycle, retired_count=0.
